hand_reg: RTL and testbench
===========================

HAND_REG -- requirements
Module: hand_reg

Interface
REQ-001 Parameter NUM_CARDS, default 3, meaning maximum cards held per hand (legal range 1..7).
REQ-002 Parameter CARD_W, default 4, meaning width of one card code.
REQ-003 Port slow_clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port resetb  input  1  reset, asynchronous and active-low.
REQ-005 Port clear  input  1  synchronous hand clear; empties the hand at the next edge.
REQ-006 Port load_card  input  1  request to append new_card to the hand.
REQ-007 Port new_card  input  CARD_W  card code to append: 1=Ace, 2..10 pips, 11..13 J/Q/K.
REQ-008 Port cards  output  NUM_CARDS*CARD_W  slot i is at bits [i*CARD_W +: CARD_W]; an empty slot reads 0.
REQ-009 Port count  output  $clog2(NUM_CARDS+1)  number of cards held.
REQ-010 Port full  output  1  high when count == NUM_CARDS.
REQ-011 Port score  output  4  baccarat hand value, 0..9.
REQ-012 Port err  output  1  sticky error: a rejected load occurred.

Function
REQ-013 An accepted load (load_card=1, clear=0, full=0, new_card in 1..13) writes new_card into slot[count], increments count by one, and updates score, all on the same edge; cards, count and score are all registered outputs.
REQ-014 Card value rule: code 1..9 gives value = code; codes 10..13 give value 0.
REQ-015 The next score is (score + value(new_card)) mod 10, computed in 5-bit arithmetic, with 10 subtracted once when the sum is 10 or more.
REQ-016 A load with full=1 is rejected: cards, count and score are unchanged and err is set to 1.
REQ-017 A load with new_card equal to 0 or greater than 13 is rejected: the hand is unchanged and err is set to 1.
REQ-018 clear=1 sets every slot, count, score and err to 0 at the next edge.
REQ-019 clear has priority over load_card in the same cycle; the load is dropped and err is not set.
REQ-020 With load_card=0 and clear=0, all state holds.
REQ-021 full is combinational from count and is true in the same cycle that count reaches NUM_CARDS.
REQ-022 err remains 1 until clear or reset; successful loads do not clear it.
REQ-023 Slots at index count or above always read 0.
REQ-024 The legal-code check applies to code values only; when CARD_W > 4, any code above 13 is rejected.

Reset
REQ-025 resetb=0 immediately forces all slots, count, score and err to 0, independent of slow_clock.
REQ-026 Reset asserted mid-operation discards the hand without completing any pending load.
REQ-027 On resetb deassertion, the first active edge behaves as a normal cycle.

Structure
REQ-028 Package baccarat_pkg holds the card codes (CARD_NONE=0, CARD_ACE=1, CARD_KING=13) and SCORE_W=4; hand_reg imports it.
REQ-029 Sub-module card_value (combinational, code in, 4-bit value out) implements REQ-014 and is shared with other scoring blocks.
REQ-030 Slot storage is a NUM_CARDS-entry array written only at index count; there is no shifting.

Verification
REQ-031 Reset then load codes 7 then 5 -> cards slot0=7, slot1=5; count=2; score=2; full=0; err=0.
REQ-032 With NUM_CARDS=3, load 1, 12, 9 -> score=0, count=3, full=1; a fourth load of 4 -> hand unchanged, err=1.
REQ-033 Load new_card=0, then new_card=14 -> count stays 0; err=1 after the first; score=0.
REQ-034 clear and load_card both high with new_card=6 on a hand holding 2 cards -> count=0, score=0, cards=0, err=0.
REQ-035 Drop resetb between clock edges with a full hand -> outputs go to 0 before the next edge; load 3 after release -> count=1, score=3.
REQ-036 Load 13, 10, 11 -> score=0 after each load; count=3; confirms that face cards count zero.

Source files
------------

// File: rtl/baccarat_pkg.sv
// -----------------------------------------------------------------------------
// baccarat_pkg
// Shared constants and helpers for the baccarat scoring blocks.
//   CARD_NONE / CARD_ACE / CARD_KING : card code landmarks (0 = no card)
//   PIP_MAX                          : highest code that scores its face value
//   SCORE_W                          : width of a hand score (0..9)
//   score_add()                      : baccarat addition, result mod 10
// -----------------------------------------------------------------------------
package baccarat_pkg;

    localparam int CARD_NONE = 0;
    localparam int CARD_ACE  = 1;
    localparam int PIP_MAX   = 9;
    localparam int CARD_KING = 13;
    localparam int SCORE_W   = 4;

    // Both operands are at most 9, so the 5-bit sum is at most 18 and a single
    // subtraction of 10 is enough to bring it back into 0..9.
    function automatic logic [SCORE_W-1:0] score_add(
        input logic [SCORE_W-1:0] score_in,
        input logic [SCORE_W-1:0] value_in
    );
        logic [SCORE_W:0] sum;
        sum = {1'b0, score_in} + {1'b0, value_in};
        if (sum >= (SCORE_W+1)'(10)) begin
            sum = sum - (SCORE_W+1)'(10);
        end
        return sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/card_value.sv
// -----------------------------------------------------------------------------
// card_value
// Combinational baccarat value of one card code.
//   code  (in,  CARD_W)  : card code, 1 = Ace, 2..10 pips, 11..13 J/Q/K
//   value (out, SCORE_W) : 1..9 for codes 1..9, 0 for everything else
// -----------------------------------------------------------------------------
module card_value
    import baccarat_pkg::*;
#(
    parameter int CARD_W = 4
) (
    input  logic [CARD_W-1:0]  code,
    output logic [SCORE_W-1:0] value
);

    logic [31:0] code_ext;

    // Widen once so the range test is independent of CARD_W.
    assign code_ext = 32'(code);

    always_comb begin
        value = '0;
        if (code_ext >= 32'(CARD_ACE) && code_ext <= 32'(PIP_MAX)) begin
            value = SCORE_W'(code_ext);
        end
    end

endmodule

// File: rtl/hand_reg.sv
// -----------------------------------------------------------------------------
// hand_reg
// Register holding one baccarat hand: card slots, card count, running score and
// a sticky error flag for rejected loads.
//   slow_clock (in)                    : sole clock, rising edge
//   resetb     (in)                    : asynchronous active-low reset
//   clear      (in)                    : synchronous hand clear, beats load_card
//   load_card  (in)                    : append new_card to the hand
//   new_card   (in,  CARD_W)           : card code to append (legal 1..13)
//   cards      (out, NUM_CARDS*CARD_W) : slot i at [i*CARD_W +: CARD_W], empty = 0
//   count      (out, CNT_W)            : number of cards held
//   full       (out)                   : count == NUM_CARDS (combinational)
//   score      (out, 4)                : hand value 0..9
//   err        (out)                   : sticky, set by any rejected load
// -----------------------------------------------------------------------------
module hand_reg
    import baccarat_pkg::*;
#(
    parameter int  NUM_CARDS = 3,
    parameter int  CARD_W    = 4,
    localparam int CNT_W     = $clog2(NUM_CARDS + 1)
) (
    input  logic                          slow_clock,
    input  logic                          resetb,
    input  logic                          clear,
    input  logic                          load_card,
    input  logic [CARD_W-1:0]             new_card,
    output logic [NUM_CARDS*CARD_W-1:0]   cards,
    output logic [CNT_W-1:0]              count,
    output logic                          full,
    output logic [SCORE_W-1:0]            score,
    output logic                          err
);

    logic [CNT_W-1:0]   count_q, count_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               err_q, err_d;

    logic [SCORE_W-1:0] card_val;
    logic               code_ok;
    logic               load_ok;
    logic               load_bad;

    card_value #(
        .CARD_W (CARD_W)
    ) u_card_value (
        .code  (new_card),
        .value (card_val)
    );

    // Legality is judged on the code value, so wide codes above KING fail too.
    assign code_ok  = (32'(new_card) >= 32'(CARD_ACE)) && (32'(new_card) <= 32'(CARD_KING));
    assign full     = (count_q == CNT_W'(NUM_CARDS));
    assign load_ok  = load_card && !clear && !full && code_ok;
    assign load_bad = load_card && !clear && (full || !code_ok);

    always_comb begin
        count_d = count_q;
        score_d = score_q;
        err_d   = err_q;
        if (clear) begin
            count_d = '0;
            score_d = '0;
            err_d   = 1'b0;
        end else if (load_ok) begin
            count_d = count_q + CNT_W'(1);
            score_d = score_add(score_q, card_val);
        end else if (load_bad) begin
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            count_q <= '0;
            score_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            score_q <= score_d;
            err_q   <= err_d;
        end
    end

    // Slot storage: each slot is written only when it is the next free index,
    // so cards never move once placed.
    for (genvar gi = 0; gi < NUM_CARDS; gi++) begin : g_slot
        logic [CARD_W-1:0] slot_q;

        always_ff @(posedge slow_clock or negedge resetb) begin
            if (!resetb) begin
                slot_q <= '0;
            end else if (clear) begin
                slot_q <= '0;
            end else if (load_ok && (count_q == CNT_W'(gi))) begin
                slot_q <= new_card;
            end
        end

        // Slots are already zero above count; the mask keeps that guarantee
        // explicit at the output.
        assign cards[gi*CARD_W +: CARD_W] = (CNT_W'(gi) < count_q) ? slot_q : '0;
    end

    assign count = count_q;
    assign score = score_q;
    assign err   = err_q;

endmodule

// File: tb/tb_hand_reg.sv
// -----------------------------------------------------------------------------
// tb_hand_reg
// Directed vectors with hand-computed expectations. The stimulus side drives one
// transaction per cycle and pushes the expected hand state into a queue; the
// monitor pops and compares after each rising edge, or on demand for the
// asynchronous reset check taken between edges.
// -----------------------------------------------------------------------------
module tb_hand_reg;

    localparam int NUM_CARDS = 3;
    localparam int CARD_W    = 4;
    localparam int CNT_W     = $clog2(NUM_CARDS + 1);

    logic                        slow_clock;
    logic                        resetb;
    logic                        clear;
    logic                        load_card;
    logic [CARD_W-1:0]           new_card;
    logic [NUM_CARDS*CARD_W-1:0] cards;
    logic [CNT_W-1:0]            count;
    logic                        full;
    logic [3:0]                  score;
    logic                        err;

    hand_reg #(
        .NUM_CARDS (NUM_CARDS),
        .CARD_W    (CARD_W)
    ) dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .clear      (clear),
        .load_card  (load_card),
        .new_card   (new_card),
        .cards      (cards),
        .count      (count),
        .full       (full),
        .score      (score),
        .err        (err)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    typedef struct {
        int                          id;
        logic [NUM_CARDS*CARD_W-1:0] cards;
        logic [CNT_W-1:0]            count;
        logic [3:0]                  score;
        logic                        full;
        logic                        err;
    } exp_t;

    exp_t exp_q[$];
    event check_ev;
    int   checks = 0;
    int   errors = 0;
    int   txn_id = 0;

    // Monitor: compares every pending expectation after an edge or an explicit
    // between-edge sample request.
    initial begin
        forever begin
            @(posedge slow_clock or check_ev);
            #1;
            while (exp_q.size() > 0) begin
                exp_t e;
                int   bad;
                e   = exp_q.pop_front();
                bad = 0;
                checks++;
                if (cards !== e.cards) begin
                    $display("FAIL txn%0d cards: got %h want %h", e.id, cards, e.cards);
                    errors++; bad++;
                end
                checks++;
                if (count !== e.count) begin
                    $display("FAIL txn%0d count: got %0d want %0d", e.id, count, e.count);
                    errors++; bad++;
                end
                checks++;
                if (score !== e.score) begin
                    $display("FAIL txn%0d score: got %0d want %0d", e.id, score, e.score);
                    errors++; bad++;
                end
                checks++;
                if (full !== e.full) begin
                    $display("FAIL txn%0d full: got %b want %b", e.id, full, e.full);
                    errors++; bad++;
                end
                checks++;
                if (err !== e.err) begin
                    $display("FAIL txn%0d err: got %b want %b", e.id, err, e.err);
                    errors++; bad++;
                end
                $display("txn %0d cards=%h count=%0d score=%0d full=%b err=%b %s",
                         e.id, cards, count, score, full, err, (bad == 0) ? "ok" : "bad");
            end
        end
    end

    task automatic push_exp(input logic [NUM_CARDS*CARD_W-1:0] c, input int n,
                            input int s, input logic f, input logic e);
        exp_t x;
        x.id    = txn_id;
        x.cards = c;
        x.count = CNT_W'(n);
        x.score = 4'(s);
        x.full  = f;
        x.err   = e;
        exp_q.push_back(x);
        txn_id++;
    endtask

    // One synchronous transaction: inputs change on the falling edge and the
    // expectation is for the state after the following rising edge.
    task automatic step(input logic clr, input logic ld, input int card,
                        input logic [NUM_CARDS*CARD_W-1:0] c, input int n,
                        input int s, input logic f, input logic e);
        @(negedge slow_clock);
        clear     = clr;
        load_card = ld;
        new_card  = CARD_W'(card);
        push_exp(c, n, s, f, e);
    endtask

    initial begin
        resetb    = 1'b0;
        clear     = 1'b0;
        load_card = 1'b0;
        new_card  = '0;

        // Reset state, sampled while reset is held.
        #12;
        push_exp(12'h000, 0, 0, 1'b0, 1'b0);
        -> check_ev;
        #3;
        resetb = 1'b1;

        // Two-card hand 7 + 5 -> score 2; then hold; then clear.
        step(0, 1, 7,  12'h007, 1, 7, 0, 0);
        step(0, 1, 5,  12'h057, 2, 2, 0, 0);
        step(0, 0, 0,  12'h057, 2, 2, 0, 0);
        step(1, 0, 0,  12'h000, 0, 0, 0, 0);

        // Ace, Queen, Nine -> 10 wraps to 0, hand full; fourth load rejected.
        step(0, 1, 1,  12'h001, 1, 1, 0, 0);
        step(0, 1, 12, 12'h0C1, 2, 1, 0, 0);
        step(0, 1, 9,  12'h9C1, 3, 0, 1, 0);
        step(0, 1, 4,  12'h9C1, 3, 0, 1, 1);
        step(0, 0, 0,  12'h9C1, 3, 0, 1, 1);

        // Clear wins over a simultaneous load and also clears err.
        step(1, 1, 6,  12'h000, 0, 0, 0, 0);

        // Clear with load on a two-card hand.
        step(0, 1, 2,  12'h002, 1, 2, 0, 0);
        step(0, 1, 3,  12'h032, 2, 5, 0, 0);
        step(1, 1, 6,  12'h000, 0, 0, 0, 0);

        // Illegal codes 0, 14, 15 are rejected; err stays set through a good load.
        step(0, 1, 0,  12'h000, 0, 0, 0, 1);
        step(0, 1, 14, 12'h000, 0, 0, 0, 1);
        step(0, 1, 15, 12'h000, 0, 0, 0, 1);
        step(0, 1, 8,  12'h008, 1, 8, 0, 1);
        step(1, 0, 0,  12'h000, 0, 0, 0, 0);

        // 9 + 9 = 18 -> 8.
        step(0, 1, 9,  12'h009, 1, 9, 0, 0);
        step(0, 1, 9,  12'h099, 2, 8, 0, 0);
        step(1, 0, 0,  12'h000, 0, 0, 0, 0);

        // Face cards and ten score zero.
        step(0, 1, 13, 12'h00D, 1, 0, 0, 0);
        step(0, 1, 10, 12'h0AD, 2, 0, 0, 0);
        step(0, 1, 11, 12'hBAD, 3, 0, 1, 0);

        // Asynchronous reset between edges on a full hand, with a load pending.
        @(negedge slow_clock);
        load_card = 1'b1;
        new_card  = 4'd4;
        #2;
        resetb = 1'b0;
        push_exp(12'h000, 0, 0, 1'b0, 1'b0);
        -> check_ev;
        #2;
        resetb    = 1'b1;
        load_card = 1'b0;

        // First edge after release behaves normally.
        step(0, 1, 3,  12'h003, 1, 3, 0, 0);
        step(0, 0, 0,  12'h003, 1, 3, 0, 0);

        repeat (3) @(posedge slow_clock);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
            errors++;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
